// File: rtl/instr_tx.sv
// UART transmitter for 16-bit FRANK6000 words: two 8N1 bytes, high byte first,
// matching the framing the instruction receiver reassembles.
module instr_tx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_tx_word,
  input  logic        i_tx_dv,
  output logic        o_tx_serial,
  output logic        o_tx_active,
  output logic        o_tx_done,
  output logic        o_ready
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]    state_q,   state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic          byte_idx_q, byte_idx_d;
  logic [7:0]    shift_q,   shift_d;
  logic [7:0]    low_q,     low_d;
  logic          serial_q,  serial_d;
  logic          active_q,  active_d;
  logic          done_q,    done_d;
  logic          ready_q,   ready_d;

  logic bit_end;
  assign bit_end = (clk_cnt_q == CNT_MAX);

  // Outputs are computed one cycle ahead so every line level comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    low_d      = low_q;
    serial_d   = serial_q;
    active_d   = active_q;
    done_d     = 1'b0;
    ready_d    = ready_q;

    case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        if (i_tx_dv) begin
          state_d    = START;
          shift_d    = i_tx_word[15:8];
          low_d      = i_tx_word[7:0];
          byte_idx_d = 1'b0;
          bit_idx_d  = 3'd0;
          clk_cnt_d  = '0;
          serial_d   = 1'b0;
          active_d   = 1'b1;
          ready_d    = 1'b0;
        end
      end

      START: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d   = DATA;
          serial_d  = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = 3'd0;
            state_d   = STOP;
            serial_d  = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            serial_d  = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      STOP: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (!byte_idx_q) begin
            // Low byte follows the high byte's stop bit with no idle gap.
            byte_idx_d = 1'b1;
            state_d    = START;
            shift_d    = low_q;
            serial_d   = 1'b0;
          end else begin
            byte_idx_d = 1'b0;
            state_d    = IDLE;
            shift_d    = '0;
            serial_d   = 1'b1;
            active_d   = 1'b0;
            ready_d    = 1'b1;
            done_d     = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      default: begin
        state_d    = IDLE;
        clk_cnt_d  = '0;
        bit_idx_d  = 3'd0;
        byte_idx_d = 1'b0;
        shift_d    = '0;
        serial_d   = 1'b1;
        active_d   = 1'b0;
        ready_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 1'b0;
      shift_q    <= '0;
      low_q      <= '0;
      serial_q   <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      low_q      <= low_d;
      serial_q   <= serial_d;
      active_q   <= active_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
    end
  end

  assign o_tx_serial = serial_q;
  assign o_tx_active = active_q;
  assign o_tx_done   = done_q;
  assign o_ready     = ready_q;

endmodule

// File: tb/tb_instr_tx.sv
// Bench for instr_tx: a fast instance (4 clocks/bit) checked cycle by cycle and a
// 217 clocks/bit instance checked through a UART receive monitor and scoreboard.
module tb_instr_tx;

  localparam int CPB      = 4;
  localparam int CPB_LOOP = 217;
  localparam int FRAME    = 20 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] txWord   = 16'h0000;
  logic        txDv     = 1'b0;
  logic        serial, active, done, ready;
  logic [15:0] loopWord = 16'h0000;
  logic        loopDv   = 1'b0;
  logic        loopSerial, loopActive, loopDone, loopReady;

  int compared   = 0;
  int mismatched = 0;
  logic [15:0] sb[$];
  int doneCount     = 0;
  int loopDoneCount = 0;
  int rxWords       = 0;
  bit loopSel       = 1'b0;

  instr_tx #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk(clk), .i_rst(rst), .i_tx_word(txWord), .i_tx_dv(txDv),
    .o_tx_serial(serial), .o_tx_active(active), .o_tx_done(done), .o_ready(ready)
  );

  instr_tx #(.CLKS_PER_BIT(CPB_LOOP)) dutLoop (
    .i_clk(clk), .i_rst(rst), .i_tx_word(loopWord), .i_tx_dv(loopDv),
    .o_tx_serial(loopSerial), .o_tx_active(loopActive), .o_tx_done(loopDone),
    .o_ready(loopReady)
  );

  // Receive monitor: mid-bit sampling of whichever line is selected, words popped from sb.
  logic       lineMon;
  assign lineMon = loopSel ? loopSerial : serial;
  bit         mBusy = 1'b0;
  bit         mByteIdx = 1'b0;
  int         mCnt = 0;
  int         mHalf;
  int         mCpb;
  logic [7:0] mByte = 8'h00;
  logic [7:0] mHigh = 8'h00;
  logic [15:0] gotW, expW;

  always @(negedge clk) begin
    if (done === 1'b1) doneCount++;
    if (loopDone === 1'b1) loopDoneCount++;
    mCpb  = loopSel ? CPB_LOOP : CPB;
    mHalf = mCpb / 2;
    if (rst) begin
      mBusy = 1'b0; mCnt = 0; mByteIdx = 1'b0;
    end else if (!mBusy) begin
      if (lineMon === 1'b0) begin mBusy = 1'b1; mCnt = 0; end
    end else begin
      mCnt++;
      if (mCnt == mHalf) begin
        compared++;
        if (lineMon !== 1'b0) begin
          mismatched++;
          $display("[TB] FAIL rx_start: line=%b expected 0", lineMon);
        end
      end else if (mCnt > mHalf && mCnt <= mHalf + 8 * mCpb && ((mCnt - mHalf) % mCpb) == 0) begin
        mByte = {lineMon, mByte[7:1]};
      end else if (mCnt == mHalf + 9 * mCpb) begin
        compared++;
        if (lineMon !== 1'b1) begin
          mismatched++;
          $display("[TB] FAIL rx_stop: line=%b expected 1", lineMon);
        end
        if (!mByteIdx) begin
          mHigh = mByte; mByteIdx = 1'b1;
        end else begin
          mByteIdx = 1'b0;
          rxWords++;
          gotW = {mHigh, mByte};
          compared++;
          if (sb.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL rx_unexpected: got %h with nothing expected", gotW);
          end else begin
            expW = sb.pop_front();
            if (gotW !== expW) begin
              mismatched++;
              $display("[TB] FAIL rx_word: got %h expected %h", gotW, expW);
            end
          end
        end
        mBusy = 1'b0;
      end
    end
  end

  task automatic startWord(input logic [15:0] w);
    int n = 0;
    while (ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    compared++;
    if (ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL ready_wait: ready=%b expected 1", ready);
    end
    txDv = 1'b1; txWord = w;
    sb.push_back(w);
  endtask

  // Checks the 80 line cycles of w cycle by cycle, then the done cycle.
  task automatic checkFrame(input logic [15:0] w, input int injectAt, input logic [15:0] injectW,
                            input bit chain, input logic [15:0] chainW);
    logic       expLine [1:FRAME];
    logic [7:0] byteVal;
    logic       level;
    for (int b = 0; b < 2; b++) begin
      byteVal = (b == 0) ? w[15:8] : w[7:0];
      for (int k = 0; k < 10; k++) begin
        level = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : byteVal[k-1];
        for (int j = 0; j < CPB; j++) expLine[b*10*CPB + k*CPB + j + 1] = level;
      end
    end
    for (int c = 1; c <= FRAME; c++) begin
      @(negedge clk);
      txDv = 1'b0; txWord = 16'($urandom);
      if (c == injectAt) begin txDv = 1'b1; txWord = injectW; end
      compared++;
      if ({serial, active, ready} !== {expLine[c], 1'b1, 1'b0}) begin
        mismatched++;
        $display("[TB] FAIL frame_%h_cycle%0d: {serial,active,ready}=%b expected %b",
                 w, c, {serial, active, ready}, {expLine[c], 1'b1, 1'b0});
      end
    end
    @(negedge clk);
    txDv = 1'b0;
    compared++;
    if ({done, ready, active, serial} !== 4'b1101) begin
      mismatched++;
      $display("[TB] FAIL done_cycle_%h: {done,ready,active,serial}=%b expected 1101",
               w, {done, ready, active, serial});
    end
    if (chain) begin
      txDv = 1'b1; txWord = chainW;
      sb.push_back(chainW);
    end else begin
      @(negedge clk);
      compared++;
      if (done !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL done_width_%h: done=%b expected 0", w, done);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; txDv = 1'b0; loopDv = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      compared++;
      if ({serial, ready, active, done} !== 4'b1100) begin
        mismatched++;
        $display("[TB] FAIL reset_idle_%0d: {serial,ready,active,done}=%b expected 1100",
                 c, {serial, ready, active, done});
      end
    end
  endtask

  task automatic test_frame();
    int d0 = doneCount;
    startWord(16'hA55A);
    checkFrame(16'hA55A, 0, 16'h0000, 1'b0, 16'h0000);
    compared++;
    if (doneCount - d0 != 1) begin
      mismatched++;
      $display("[TB] FAIL frame_done_count: got %0d expected 1", doneCount - d0);
    end
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL frame_sb_empty: %0d words pending expected 0", sb.size());
    end
  endtask

  task automatic test_ignore_midframe();
    int d0 = doneCount;
    bit sawActive = 1'b0;
    startWord(16'hA55A);
    checkFrame(16'hA55A, 30, 16'h1234, 1'b0, 16'h0000);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (active !== 1'b0 || serial !== 1'b1) sawActive = 1'b1;
    end
    compared++;
    if (sawActive) begin
      mismatched++;
      $display("[TB] FAIL ignore_no_second_frame: line activity=%b expected 0", sawActive);
    end
    compared++;
    if (doneCount - d0 != 1) begin
      mismatched++;
      $display("[TB] FAIL ignore_done_count: got %0d expected 1", doneCount - d0);
    end
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL ignore_sb_empty: %0d words pending expected 0", sb.size());
    end
  endtask

  // The done cycle holds the line high, so the gap is the stop bit plus that cycle.
  task automatic test_back_to_back();
    startWord(16'h0001);
    checkFrame(16'h0001, 0, 16'h0000, 1'b1, 16'hFFFF);
    checkFrame(16'hFFFF, 0, 16'h0000, 1'b0, 16'h0000);
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL b2b_sb_empty: %0d words pending expected 0", sb.size());
    end
  endtask

  task automatic test_reset_midframe();
    startWord(16'hC3A7);
    @(negedge clk);
    txDv = 1'b0;
    repeat (11) @(negedge clk);
    compared++;
    if (active !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL midreset_active_before: active=%b expected 1", active);
    end
    rst = 1'b1;
    #1;
    compared++;
    if ({serial, ready, active, done} !== 4'b1100) begin
      mismatched++;
      $display("[TB] FAIL midreset_async: {serial,ready,active,done}=%b expected 1100",
               {serial, ready, active, done});
    end
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    startWord(16'h00FF);
    checkFrame(16'h00FF, 0, 16'h0000, 1'b0, 16'h0000);
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL midreset_sb_empty: %0d words pending expected 0", sb.size());
    end
  endtask

  task automatic test_loopback();
    logic [15:0] words[$];
    int rx0 = rxWords;
    int ld0 = loopDoneCount;
    int n;
    words.push_back(16'h0000);
    words.push_back(16'hFFFF);
    words.push_back(16'h8001);
    for (int i = 0; i < 8; i++) words.push_back(16'($urandom));
    loopSel = 1'b1;
    foreach (words[i]) begin
      n = 0;
      while (loopReady !== 1'b1 && n < 25 * CPB_LOOP) begin @(negedge clk); n++; end
      compared++;
      if (loopReady !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL loop_ready_wait_%0d: ready=%b expected 1", i, loopReady);
      end
      loopDv = 1'b1; loopWord = words[i];
      sb.push_back(words[i]);
      @(negedge clk);
      loopDv = 1'b0; loopWord = 16'($urandom);
    end
    n = 0;
    while ((loopReady !== 1'b1 || sb.size() != 0) && n < 25 * CPB_LOOP) begin
      @(negedge clk); n++;
    end
    repeat (2) @(negedge clk);
    compared++;
    if (rxWords - rx0 != words.size()) begin
      mismatched++;
      $display("[TB] FAIL loop_rx_count: got %0d expected %0d", rxWords - rx0, words.size());
    end
    compared++;
    if (loopDoneCount - ld0 != words.size()) begin
      mismatched++;
      $display("[TB] FAIL loop_done_count: got %0d expected %0d", loopDoneCount - ld0, words.size());
    end
    compared++;
    if (sb.size() != 0 || loopActive !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL loop_drained: pending=%0d active=%b expected 0/0", sb.size(), loopActive);
    end
    loopSel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_ignore_midframe();
    test_back_to_back();
    test_reset_midframe();
    test_loopback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "[TB] watchdog");
  end

endmodule
